// File: rtl/fiat_25519_carry_mul_mac_pipe.sv
// Pipelined signed limb multiplier with optional multiply-accumulate for the fiat_25519 carry_mul datapath.
// Latency: NUM_STAGE enabled cycles (MODE=0) or NUM_STAGE+1 after the item flagged last (MODE=1).
// Backpressure: none; a global ce stalls every register, so a held dout_vld is qualified with ce.
//
// Ports:
//   ap_clk, ap_rst     rising-edge clock, synchronous active-high reset (wins over ce)
//   ce                 clock enable for all state
//   din0, din1         two's complement operands, sampled with din_vld when ce=1
//   din_first/last     MODE=1 only: bracket the products that make one sum
//   dout, dout_vld     result (modulo 2^dout_WIDTH) and its one-result strobe
module fiat_25519_carry_mul_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 64,
  parameter int MODE       = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din_vld,
  input  logic                  din_first,
  input  logic                  din_last,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld
);

  localparam int PROD_W = din0_WIDTH + din1_WIDTH;
  localparam int WIDE_W = (PROD_W > dout_WIDTH) ? PROD_W : dout_WIDTH;
  localparam int LAST   = NUM_STAGE - 1;

  generate
    if (NUM_STAGE < 1 || NUM_STAGE > 6) begin : g_bad_stage
      $error("fiat_25519_carry_mul_mac_pipe: NUM_STAGE must be in 1..6");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("fiat_25519_carry_mul_mac_pipe: MODE must be 0 or 1");
    end
  endgenerate

  // Full-precision signed product, then sign-extended or truncated to the
  // result width. The multiply sits in front of stage 0; synthesis is free
  // to retime it into the following registers.
  logic signed [PROD_W-1:0]     op_a;
  logic signed [PROD_W-1:0]     op_b;
  logic signed [PROD_W-1:0]     prod;
  logic signed [WIDE_W-1:0]     prod_wide;
  logic        [dout_WIDTH-1:0] prod_fit;

  assign op_a      = PROD_W'($signed(din0));
  assign op_b      = PROD_W'($signed(din1));
  assign prod      = op_a * op_b;
  assign prod_wide = WIDE_W'(prod);
  assign prod_fit  = prod_wide[dout_WIDTH-1:0];

  // Product pipeline. Data registers only load behind a valid slot, so the
  // final stage always holds the most recent valid product across bubbles.
  logic [dout_WIDTH-1:0] pipe_dat [NUM_STAGE];
  logic [NUM_STAGE-1:0]  pipe_vld;
  logic [NUM_STAGE-1:0]  pipe_first;
  logic [NUM_STAGE-1:0]  pipe_last;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pipe_vld   <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        pipe_dat[i] <= '0;
      end
    end else if (ce) begin
      pipe_vld[0]   <= din_vld;
      pipe_first[0] <= din_first;
      pipe_last[0]  <= din_last;
      if (din_vld) begin
        pipe_dat[0] <= prod_fit;
      end
      for (int i = 1; i < NUM_STAGE; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_first[i] <= pipe_first[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  generate
    if (MODE == 1) begin : g_mac
      logic [dout_WIDTH-1:0] acc_q;
      logic [dout_WIDTH-1:0] acc_nxt;
      logic [dout_WIDTH-1:0] acc_dout;
      logic                  acc_vld;

      // A first item restarts the sum, dropping any unfinished partial sum.
      // Without first, the product lands on whatever ACC holds (0 after reset,
      // or the previous completed sum).
      always_comb begin
        acc_nxt = acc_q + pipe_dat[LAST];
        if (pipe_first[LAST]) begin
          acc_nxt = pipe_dat[LAST];
        end
      end

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          acc_q    <= '0;
          acc_dout <= '0;
          acc_vld  <= 1'b0;
        end else if (ce) begin
          acc_vld <= pipe_vld[LAST] & pipe_last[LAST];
          if (pipe_vld[LAST]) begin
            acc_q <= acc_nxt;
            if (pipe_last[LAST]) begin
              acc_dout <= acc_nxt;
            end
          end
        end
      end

      assign dout     = acc_dout;
      assign dout_vld = acc_vld;
    end else begin : g_mul
      // first/last only steer the accumulator, which is absent here.
      logic unused_flags;
      assign unused_flags = ^{pipe_first, pipe_last};

      assign dout     = pipe_dat[LAST];
      assign dout_vld = pipe_vld[LAST];
    end
  endgenerate

endmodule

// File: doc/fiat_25519_carry_mul_mac_pipe.md
Name: fiat_25519_carry_mul_mac_pipe

Overview:
- Parametrised, pipelined signed multiplier with an optional multiply-accumulate mode, for the fiat_25519 carry_mul datapath.
- Replaces single-cycle combinational limb multipliers where timing needs registered stages, or where a sum of limb products must be formed in one unit.
- Carries a valid/first/last sideband through the pipeline, with a global clock-enable stall compatible with HLS ce-style scheduling.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 3, multiplier pipeline depth in registers. Legal range 1..6; any other value is an elaboration error.
- din0_WIDTH, 32, signed width of operand A.
- din1_WIDTH, 7, signed width of operand B.
- dout_WIDTH, 64, result and accumulator width.
- MODE, 0, 0 = plain multiply, 1 = multiply-accumulate.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, every register holds.
- din0  in  din0_WIDTH  operand A, two's complement.
- din1  in  din1_WIDTH  operand B, two's complement.
- din_vld  in  1  operands valid this cycle; sampled only when ce=1.
- din_first  in  1  MODE=1: this product starts a new sum. Ignored in MODE=0.
- din_last  in  1  MODE=1: this product ends the sum. Ignored in MODE=0.
- dout  out  dout_WIDTH  result, two's complement.
- dout_vld  out  1  dout valid; high for exactly one enabled cycle per result.

Behaviour:
- Reset, when ap_rst=1 at an edge, regardless of ce:
  - dout=0, dout_vld=0, accumulator=0.
  - All pipeline data and valid/first/last flags cleared.
  - Any in-flight items are discarded with no output.
- Product arithmetic:
  - P = signed(din0) * signed(din1), full precision of din0_WIDTH+din1_WIDTH bits.
  - P is then sign-extended or truncated to dout_WIDTH bits, i.e. reduced modulo 2^dout_WIDTH.
- Pipeline:
  - NUM_STAGE registers hold data and the vld/first/last flags.
  - Registers may be retimed across the multiply, provided total latency and the results are unchanged.
  - Bubbles (din_vld=0) propagate as invalid slots; data in invalid slots is don't-care, but dout must hold its last valid value.
- ce:
  - When ce=0, all stages, the accumulator, dout and dout_vld hold.
  - Latency is counted in ce=1 cycles only.
  - An output whose dout_vld is held high by ce=0 is still a single result; the consumer qualifies it with ce.
- MODE=0:
  - dout and dout_vld reflect an input exactly NUM_STAGE enabled cycles after acceptance.
  - Throughput is one result per enabled cycle.
- MODE=1:
  - One accumulate stage is added; latency to dout is NUM_STAGE+1 enabled cycles after the input flagged last.
  - Accumulate register ACC, dout_WIDTH bits, updated when a valid product arrives at the accumulate stage:
    - first=1: ACC = P.
    - first=0: ACC = ACC + P, modulo 2^dout_WIDTH (wrap, no saturation, no overflow flag).
  - last=1: the same edge loads dout with the new ACC value and sets dout_vld=1. Otherwise dout_vld=0 and dout holds.
  - first=1 and last=1 together: dout = P, giving a single-term sum.
  - A valid item with first=0 arriving after reset or after a completed sum accumulates onto the current ACC, which is 0 after reset. This is defined behaviour, not an error.
  - A new first before a last: the partial sum is discarded silently and ACC restarts at the new P.
  - Back-to-back sums (last at cycle n, first at cycle n+1) run at full rate, with no bubble required.
- dout_vld is never X after reset; dout is 0 until the first result.

Test Plan:
- MODE=0, NUM_STAGE=3, din0=0x7FFFFFFF, din1=-64 (7'h40), din_vld pulse, ce=1 → after 3 cycles dout=0xFFFFFFE0_00000040 (-137438953408), dout_vld high for 1 cycle.
- MODE=0, streaming 8 consecutive pairs (i, -i) for i=0..7, with ce low for 2 cycles at cycle 4 → outputs -i*i in order, each 3 enabled cycles after its input; dout/dout_vld frozen during the ce=0 cycles.
- MODE=1, NUM_STAGE=2, sum of (3,5) first, (-4,7), (10,-2) last → exactly one dout_vld, 3 cycles after the last input, dout=-33.
- MODE=1, first&last on one item (-1,-1), then immediately a 2-term sum (2,2) first, (2,2) last → dout=1, then dout=8, with no bubble between groups.
- MODE=1, dout_WIDTH=8, din0_WIDTH=8, din1_WIDTH=7: products 127*63 (first), then 127*63 (last) → dout = (8001+8001) mod 256 = 0x82, i.e. a wrapped result.
- Reset mid-sum: assert ap_rst for 1 cycle after the 2nd of 3 items → dout=0, dout_vld=0, and no output for the aborted sum. A subsequent first/last item (6,7) gives dout=42.
